// File: rtl/arith_core_32_pkg.sv
// Shared constants and the engine state type for the arith_core_32 block.
package arith_core_32_pkg;

   localparam int WIDTH = 32;
   localparam int ITERS = 32;
   localparam int CNT_W = $clog2(ITERS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

endpackage

// File: rtl/arith_seq_ctrl.sv
// IDLE/BUSY/DONE sequencer shared by the multiply and divide engines.
// A stepping engine advances only when ena is high (valid); DONE is sticky until rst.
module arith_seq_ctrl
   import arith_core_32_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   ena,
   output state_t state,
   output logic   dne,
   output logic   step,
   output logic   last
);

   logic [CNT_W-1:0] cnt;

   assign step = (state == BUSY) && ena;
   assign last = step && (cnt == CNT_W'(ITERS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         dne   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ena) begin
                  state <= BUSY;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               if (last) begin
                  state <= DONE;
                  dne   <= 1'b1;
               end else if (step) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/arith_core_32.sv
// Combinational adder plus sequential shift-add multiplier and restoring divider.
// Each engine captures operands on its first enabled edge and iterates once per enabled edge.
module arith_core_32 #(
   parameter int WIDTH = arith_core_32_pkg::WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               c_in,
   input  logic               mul_ena,
   input  logic               div_ena,
   output logic [WIDTH-1:0]   s,
   output logic               c_out,
   output logic [2*WIDTH-1:0] p,
   output logic               mul_dne,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH-1:0]   r,
   output logic               div_dne
);
   import arith_core_32_pkg::*;

   assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};

   state_t mul_state, div_state;
   logic   mul_step, mul_last, div_step, div_last;

   arith_seq_ctrl u_mul_ctrl (
      .clk(clk), .rst(rst), .ena(mul_ena),
      .state(mul_state), .dne(mul_dne), .step(mul_step), .last(mul_last)
   );

   arith_seq_ctrl u_div_ctrl (
      .clk(clk), .rst(rst), .ena(div_ena),
      .state(div_state), .dne(div_dne), .step(div_step), .last(div_last)
   );

   // Multiplier: high half accumulates, low half starts as the multiplier and shifts out.
   logic [WIDTH-1:0]   mul_a;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mul_a : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, prod[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_a <= '0;
         prod  <= '0;
         p     <= '0;
      end else if ((mul_state == IDLE) && mul_ena) begin
         mul_a <= a;
         prod  <= {{WIDTH{1'b0}}, b};
      end else if (mul_step) begin
         prod <= mul_next;
         if (mul_last) p <= mul_next;
      end
   end

   // Divider: a zero divisor never borrows, which yields all-ones quotient and r = a.
   logic [WIDTH-1:0] div_b, div_rem, div_quo;
   logic [WIDTH:0]   div_shift, div_trial;
   logic             div_fits;
   logic [WIDTH-1:0] div_rem_next, div_quo_next;

   assign div_shift    = {div_rem, div_quo[WIDTH-1]};
   assign div_trial    = div_shift - {1'b0, div_b};
   assign div_fits     = ~div_trial[WIDTH];
   assign div_rem_next = div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_quo_next = {div_quo[WIDTH-2:0], div_fits};

   always_ff @(posedge clk) begin
      if (rst) begin
         div_b   <= '0;
         div_rem <= '0;
         div_quo <= '0;
         q       <= '0;
         r       <= '0;
      end else if ((div_state == IDLE) && div_ena) begin
         div_b   <= b;
         div_rem <= '0;
         div_quo <= a;
      end else if (div_step) begin
         div_rem <= div_rem_next;
         div_quo <= div_quo_next;
         if (div_last) begin
            q <= div_quo_next;
            r <= div_rem_next;
         end
      end
   end

endmodule

// File: tb/tb_arith_core_32.sv
// Randomized scoreboard bench for arith_core_32: drivers push expected results,
// a negedge monitor pops them when a done flag rises and checks result and latency.
module tb_arith_core_32;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic        c_in, mul_ena, div_ena;
   logic [31:0] s, q, r;
   logic        c_out, mul_dne, div_dne;
   logic [63:0] p;

   arith_core_32 #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in),
      .mul_ena(mul_ena), .div_ena(div_ena),
      .s(s), .c_out(c_out), .p(p), .mul_dne(mul_dne),
      .q(q), .r(r), .div_dne(div_dne)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int errors = 0;
   int checks = 0;
   bit mon_on = 1'b0;

   logic [63:0] mul_exp_q[$];
   int          mul_due_q[$];
   logic [63:0] div_exp_q[$];
   int          div_due_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor
   bit          mul_dne_d = 1'b0, div_dne_d = 1'b0;
   logic [63:0] p_hold, qr_hold;

   always @(negedge clk) begin
      if (mon_on) begin
         if (mul_dne && !mul_dne_d) begin
            if (mul_exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL mul_unexpected_done: got dne=1 expected no pending multiply");
            end else begin
               chk("mul_p", p, mul_exp_q.pop_front());
               chk("mul_latency", 64'(cyc), 64'(mul_due_q.pop_front()));
            end
            p_hold = p;
         end else if (mul_dne) chk("mul_hold", p, p_hold);
         else chk("mul_p_zero", p, 64'd0);

         if (div_dne && !div_dne_d) begin
            if (div_exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL div_unexpected_done: got dne=1 expected no pending divide");
            end else begin
               chk("div_qr", {q, r}, div_exp_q.pop_front());
               chk("div_latency", 64'(cyc), 64'(div_due_q.pop_front()));
            end
            qr_hold = {q, r};
         end else if (div_dne) chk("div_hold", {q, r}, qr_hold);
         else chk("div_qr_zero", {q, r}, 64'd0);
      end
      mul_dne_d = mul_dne;
      div_dne_d = div_dne;
   end

   // Drivers
   task automatic check_add(input logic [31:0] aa, input logic [31:0] bb, input logic cc);
      logic [32:0] e;
      a = aa; b = bb; c_in = cc;
      e = {1'b0, aa} + {1'b0, bb} + {32'b0, cc};
      #1;
      chk("adder", 64'({c_out, s}), 64'(e));
   endtask

   task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input bit dm, input bit dd,
                         input int pause_at, input int pause_len, input bit ena_in_rst);
      int cap;
      int t;
      @(negedge clk);
      rst = 1'b1; a = aa; b = bb;
      mul_ena = dm & ena_in_rst; div_ena = dd & ena_in_rst;
      @(negedge clk);
      rst = 1'b0; mul_ena = dm; div_ena = dd;
      cap = cyc + 1;
      if (dm) begin
         mul_exp_q.push_back(64'(aa) * 64'(bb));
         mul_due_q.push_back(cap + 32 + pause_len);
      end
      if (dd) begin
         div_exp_q.push_back((bb == 0) ? {32'hFFFF_FFFF, aa} : {aa / bb, aa % bb});
         div_due_q.push_back(cap + 32 + pause_len);
      end
      @(negedge clk);
      a = $urandom; b = $urandom;
      for (int i = 0; i < pause_at; i++) begin
         @(negedge clk);
         a = $urandom; b = $urandom;
      end
      if (pause_len > 0) begin
         mul_ena = 1'b0; div_ena = 1'b0;
         repeat (pause_len) @(negedge clk);
         mul_ena = dm; div_ena = dd;
      end
      t = 0;
      while (!((!dm || mul_dne) && (!dd || div_dne)) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done within 200 cycles expected done");
      end
      repeat (4) begin
         @(negedge clk);
         mul_ena = dm & 1'($urandom); div_ena = dd & 1'($urandom);
         a = $urandom; b = $urandom;
      end
      mul_ena = 1'b0; div_ena = 1'b0;
   endtask

   task automatic run_abort();
      @(negedge clk);
      rst = 1'b1; mul_ena = 1'b0; div_ena = 1'b0;
      @(negedge clk);
      rst = 1'b0; a = $urandom; b = $urandom_range(1, 1000);
      mul_ena = 1'b1; div_ena = 1'b1;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_p", p, 64'd0);
      chk("abort_qr", {q, r}, 64'd0);
      chk("abort_dne", {62'd0, mul_dne, div_dne}, 64'd0);
      mul_ena = 1'b0; div_ena = 1'b0;
      run_op(32'd9, 32'd3, 1'b0, 1'b1, 0, 0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; a = '0; b = '0; c_in = 1'b0; mul_ena = 1'b0; div_ena = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_p", p, 64'd0);
      chk("rst_qr", {q, r}, 64'd0);
      chk("rst_dne", {62'd0, mul_dne, div_dne}, 64'd0);
      mon_on = 1'b1;

      check_add(32'hFFFF_FFFF, 32'h0, 1'b1);
      check_add(32'd5, ~32'd3, 1'b1);
      for (int i = 0; i < 6; i++) begin
         rst = 1'($urandom);
         check_add($urandom, $urandom, 1'($urandom));
      end
      @(negedge clk);
      rst = 1'b0; a = '0; b = '0;

      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0, 1'b0);
      run_op(32'd100, 32'd7, 1'b0, 1'b1, 0, 0, 1'b0);
      run_op(32'd7, 32'd0, 1'b0, 1'b1, 0, 0, 1'b0);
      run_op(32'd6, 32'd7, 1'b1, 1'b0, 12, 5, 1'b0);
      run_abort();
      run_op(32'd20, 32'd6, 1'b1, 1'b1, 0, 0, 1'b0);
      run_op(32'd0, 32'd0, 1'b1, 1'b1, 0, 0, 1'b1);

      for (int i = 0; i < 20; i++) begin
         logic [31:0] ra, rb;
         int          mode;
         int          plen;
         ra   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         mode = $urandom_range(0, 3);
         rb   = (mode == 0) ? 32'd0 : (mode == 1) ? 32'($urandom_range(1, 255)) : $urandom;
         mode = $urandom_range(1, 3);
         plen = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
         run_op(ra, rb, mode[0], mode[1], $urandom_range(0, 31), plen, 1'($urandom));
      end

      @(negedge clk);
      chk("mul_queue_empty", 64'(mul_exp_q.size()), 64'd0);
      chk("div_queue_empty", 64'(div_exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
